// File: rtl/mac_job_sequencer.sv
// mac_job_sequencer
// Drives one dot-product job through an external M-by-N combinational multiplier.
// Operand pairs arrive over a valid/ready handshake and are registered onto the
// multiplier inputs. Each returned product is added one cycle after its pair was
// accepted, so pairs can stream at one per cycle. The final sum is held until the
// consumer takes it.
module mac_job_sequencer #(
    parameter int unsigned M     = 4,   // multiplicand width
    parameter int unsigned N     = 3,   // multiplier width
    parameter int unsigned ACC_W = 16,  // accumulator width, must be >= M+N
    parameter int unsigned CNT_W = 8    // job length counter width
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [M-1:0]       num1,
    input  logic [N-1:0]       num2,
    output logic [M-1:0]       mul_a,
    output logic [N-1:0]       mul_b,
    input  logic [M+N-1:0]     mul_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   acc_out,
    output logic               busy,
    output logic               overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;     // pairs still to accept
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic [M-1:0]       mul_a_q, mul_a_d;
    logic [N-1:0]       mul_b_q, mul_b_d;
    logic               pv_q,    pv_d;      // mul_p carries a product still to be added
    logic               ovf_q,   ovf_d;
    logic [ACC_W:0]     acc_sum;            // one extra bit catches the carry out
    logic               accept;

    // Handshake and status flags decode straight from the state register.
    assign in_ready  = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid && in_ready;

    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign acc_out  = acc_q;
    assign overflow = ovf_q;

    // Next-state logic: job sequencing, operand capture and accumulation.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        pv_d    = 1'b0;
        ovf_d   = ovf_q;

        // The product on mul_p belongs to the pair accepted at the previous edge.
        acc_sum = {1'b0, acc_q} + {1'b0, ACC_W'(mul_p)};
        if (pv_q) begin
            acc_d = acc_sum[ACC_W-1:0];
            ovf_d = ovf_q | acc_sum[ACC_W];
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    mul_a_d = num1;
                    mul_b_d = num2;
                    pv_d    = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last product is added by the pv_q path above at this edge.
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-high reset; a reset abandons any job.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            pv_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            pv_q    <= pv_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer. Two instances share the stimulus: the
// default 16-bit accumulator and an 8-bit one for the wrap/overflow case. The
// bench supplies the combinational multiplier each instance drives.
module tb_mac_job_sequencer;

    localparam int M     = 4;
    localparam int N     = 3;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [M-1:0]     num1;
    logic [N-1:0]     num2;
    logic             out_ready;

    // 16-bit accumulator instance
    logic             in_ready, out_valid, busy, overflow;
    logic [M-1:0]     mul_a;
    logic [N-1:0]     mul_b;
    logic [M+N-1:0]   mul_p;
    logic [15:0]      acc_out;

    // 8-bit accumulator instance
    logic             in_ready8, out_valid8, busy8, overflow8;
    logic [M-1:0]     mul_a8;
    logic [N-1:0]     mul_b8;
    logic [M+N-1:0]   mul_p8;
    logic [7:0]       acc_out8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // External multipliers: product of the registered operands.
    assign mul_p  = {3'b000, mul_a}  * {4'b0000, mul_b};
    assign mul_p8 = {3'b000, mul_a8} * {4'b0000, mul_b8};

    mac_job_sequencer #(.M(M), .N(N), .ACC_W(16), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .num1(num1), .num2(num2),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .busy(busy), .overflow(overflow)
    );

    mac_job_sequencer #(.M(M), .N(N), .ACC_W(8), .CNT_W(CNT_W)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready8),
        .num1(num1), .num2(num2),
        .mul_a(mul_a8), .mul_b(mul_b8), .mul_p(mul_p8),
        .out_valid(out_valid8), .out_ready(out_ready),
        .acc_out(acc_out8), .busy(busy8), .overflow(overflow8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle so inputs change and outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic [M-1:0] a, input logic [N-1:0] b);
        in_valid = 1'b1;
        num1     = a;
        num2     = b;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        num1 = '0; num2 = '0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_acc", acc_out, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);

        // 1: len=3, back-to-back (3,2),(15,7),(1,1) -> 6+105+1 = 112
        start = 1'b1; len = 8'd3; tick(); start = 1'b0;
        check("t1_in_ready", in_ready, 1);
        check("t1_busy", busy, 1);
        in_valid = 1'b1;
        num1 = 4'd3;  num2 = 3'd2; tick();
        num1 = 4'd15; num2 = 3'd7; tick();
        check("t1_mul_a", mul_a, 15);
        check("t1_mul_b", mul_b, 7);
        check("t1_acc_partial", acc_out, 6);
        num1 = 4'd1;  num2 = 3'd1; tick();   // last accept
        in_valid = 1'b0;
        check("t1_drain_in_ready", in_ready, 0);
        check("t1_drain_out_valid", out_valid, 0);
        check("t1_drain_acc", acc_out, 111);
        tick();
        check("t1_out_valid", out_valid, 1);
        check("t1_acc", acc_out, 112);
        check("t1_overflow", overflow, 0);
        tick();
        check("t1_idle_busy", busy, 0);
        check("t1_idle_out_valid", out_valid, 0);

        // 2: len=0 -> DONE next cycle with sum 0, no in_ready
        start = 1'b1; len = 8'd0; tick(); start = 1'b0;
        check("t2_out_valid", out_valid, 1);
        check("t2_acc", acc_out, 0);
        check("t2_in_ready", in_ready, 0);
        tick();
        check("t2_idle_busy", busy, 0);
        check("t2_idle_in_ready", in_ready, 0);

        // 3: len=2, (5,3), 4-cycle gap, (2,7) -> 15+14 = 29
        start = 1'b1; len = 8'd2; tick(); start = 1'b0;
        pair(4'd5, 3'd3);
        tick();
        check("t3_gap_acc1", acc_out, 15);
        tick(); tick(); tick();
        check("t3_gap_acc4", acc_out, 15);
        check("t3_gap_in_ready", in_ready, 1);
        check("t3_gap_mul_a", mul_a, 5);
        pair(4'd2, 3'd7);
        check("t3_drain_acc", acc_out, 15);
        tick();
        check("t3_out_valid", out_valid, 1);
        check("t3_acc", acc_out, 29);
        tick();

        // 4: out_ready held low in DONE; start pulses ignored
        out_ready = 1'b0;
        start = 1'b1; len = 8'd1; tick(); start = 1'b0;
        pair(4'd3, 3'd3);
        tick();
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; len = 8'd5;
            tick();
            check("t4_hold_out_valid", out_valid, 1);
            check("t4_hold_acc", acc_out, 9);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t4_idle_busy", busy, 0);
        check("t4_idle_out_valid", out_valid, 0);

        // 5: three (15,7) pairs -> 315; 8-bit instance wraps to 59 with overflow
        start = 1'b1; len = 8'd3; tick(); start = 1'b0;
        in_valid = 1'b1; num1 = 4'd15; num2 = 3'd7;
        tick(); tick(); tick();
        in_valid = 1'b0;
        tick();
        check("t5_out_valid8", out_valid8, 1);
        check("t5_acc8", acc_out8, 59);
        check("t5_overflow8", overflow8, 1);
        check("t5_acc16", acc_out, 315);
        check("t5_overflow16", overflow, 0);
        tick();
        check("t5_idle_overflow8_sticky", overflow8, 1);
        start = 1'b1; len = 8'd1; tick(); start = 1'b0;
        check("t5_restart_overflow8", overflow8, 0);
        pair(4'd1, 3'd1);
        tick();
        check("t5b_out_valid8", out_valid8, 1);
        check("t5b_acc8", acc_out8, 1);
        check("t5b_overflow8", overflow8, 0);
        tick();

        // 6: reset mid-RUN after 2 of 4 pairs, then a fresh len=1 (2,3) job
        start = 1'b1; len = 8'd4; tick(); start = 1'b0;
        in_valid = 1'b1;
        num1 = 4'd1; num2 = 3'd2; tick();
        num1 = 4'd3; num2 = 3'd1; tick();
        in_valid = 1'b0;
        check("t6_pre_rst_acc", acc_out, 2);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_rst_acc", acc_out, 0);
        check("t6_rst_mul_a", mul_a, 0);
        check("t6_rst_mul_b", mul_b, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_in_ready", in_ready, 0);
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_overflow", overflow, 0);
        tick();
        check("t6_rst_no_accum", acc_out, 0);
        start = 1'b1; len = 8'd1; tick(); start = 1'b0;
        pair(4'd2, 3'd3);
        tick();
        check("t6_out_valid", out_valid, 1);
        check("t6_acc", acc_out, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
